// File: rtl/disp_n_fifo.sv
// rtl/disp_n_fifo.sv - CH-channel dispatcher: one input stream routed by in_dest into per-channel FWFT FIFOs.
// Optional DISP_N_ERR_EN adds sticky per-channel err_underflow flags.
module disp_n_fifo #(
  parameter int DATA_W    = 8,
  parameter int CH        = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [CW-1:0]        in_dest,
  output logic                 in_ready,
  input  logic [CH-1:0]        read,
  output logic [CH*DATA_W-1:0] out_data,
  output logic [CH-1:0]        out_valid,
  output logic [CH-1:0]        almost_full
`ifdef DISP_N_ERR_EN
  ,
  output logic [CH-1:0]        err_underflow
`endif
);

  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0] AF_CNT   = (PW + 1)'(AF_THRESH);

  logic [PW:0]   count  [CH];
  logic [PW-1:0] wr_ptr [CH];
  logic [PW-1:0] rd_ptr [CH];
  logic [CH-1:0] wr_en;
  logic [CH-1:0] pop;
  logic          push;

  // in_ready only looks at registered counts, so it never depends on read.
  assign in_ready = reset && (count[in_dest] != FULL_CNT);
  assign push     = in_valid && in_ready;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_en[i] = push && (in_dest == CW'(i));
    assign pop[i]   = read[i] && (count[i] != '0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({wr_en[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end

    // Storage is intentionally unreset; out_data is gated by count instead.
    always_ff @(posedge clk) begin
      if (wr_en[i]) mem[wr_ptr[i]] <= in_data;
    end

    assign out_valid[i]                   = (count[i] != '0);
    assign out_data[i*DATA_W +: DATA_W]   = out_valid[i] ? mem[rd_ptr[i]] : '0;
    assign almost_full[i]                 = (count[i] >= AF_CNT);
  end

`ifdef DISP_N_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_underflow <= '0;
    else        err_underflow <= err_underflow | (read & ~out_valid);
  end
`endif

endmodule

// File: tb/tb_disp_n_fifo.sv
// tb/tb_disp_n_fifo.sv - directed table and sequence checks for disp_n_fifo (default parameters).
module tb_disp_n_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        in_ready;
  logic [3:0]  read;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  almost_full;
`ifdef DISP_N_ERR_EN
  logic [3:0]  err_underflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_n_fifo #(.DATA_W(8), .CH(4), .DEPTH(8), .AF_THRESH(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_dest(in_dest), .in_ready(in_ready), .read(read), .out_data(out_data),
    .out_valid(out_valid), .almost_full(almost_full)
`ifdef DISP_N_ERR_EN
    , .err_underflow(err_underflow)
`endif
  );

  typedef struct {
    logic        v;
    logic [1:0]  dest;
    logic [7:0]  data;
    logic [3:0]  rd;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [3:0]  exp_af;
    logic [31:0] exp_od;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] dat, input logic [3:0] rd);
    in_valid = v;
    in_dest  = d;
    in_data  = dat;
    read     = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    tick();
  endtask

  initial begin
    int npush;
    int npop;
    logic [7:0] lane;

    reset = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset_almost_full", {28'd0, almost_full}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    // Routing table
    vt[0] = '{1'b1, 2'd0, 8'hA0, 4'b0000, 1'b1, 4'b0001, 4'b0000, 32'h000000A0};
    vt[1] = '{1'b1, 2'd1, 8'hA1, 4'b0000, 1'b1, 4'b0011, 4'b0000, 32'h0000A1A0};
    vt[2] = '{1'b1, 2'd2, 8'hA2, 4'b0000, 1'b1, 4'b0111, 4'b0000, 32'h00A2A1A0};
    vt[3] = '{1'b1, 2'd3, 8'hA3, 4'b0000, 1'b1, 4'b1111, 4'b0000, 32'hA3A2A1A0};
    vt[4] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 4'b0000, 32'h00000000};
    for (int k = 0; k < 5; k++) begin
      drive(vt[k].v, vt[k].dest, vt[k].data, vt[k].rd);
      chk($sformatf("vec%0d_in_ready", k), {31'd0, in_ready}, {31'd0, vt[k].exp_rdy});
      tick();
      chk($sformatf("vec%0d_out_valid", k), {28'd0, out_valid}, {28'd0, vt[k].exp_ov});
      chk($sformatf("vec%0d_almost_full", k), {28'd0, almost_full}, {28'd0, vt[k].exp_af});
      chk($sformatf("vec%0d_out_data", k), out_data, vt[k].exp_od);
    end

    // Fill channel 2
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 2'd2, 8'h20 + 8'(k - 1), 4'b0000);
      tick();
      chk($sformatf("fill%0d_af2", k), {31'd0, almost_full[2]}, {31'd0, (k >= 6)});
    end
    drive(1'b1, 2'd2, 8'hEE, 4'b0000);
    chk("full_ready_dest2", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 2'd0, 8'hEE, 4'b0000);
    chk("full_ready_dest0", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 2'd2, 8'hEE, 4'b0000);
    tick();
    tick();
    chk("held_head2", {24'd0, out_data[23:16]}, 32'h20);
    chk("held_ready2", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 2'd2, 8'h00, 4'b0100);
      chk($sformatf("drain2_word%0d", k), {24'd0, out_data[23:16]}, 32'h20 + k);
      tick();
      chk($sformatf("drain2_af%0d", k), {31'd0, almost_full[2]}, {31'd0, (k < 2)});
    end
    chk("drain2_empty", {31'd0, out_valid[2]}, 32'd0);

    // Order and wrap on channel 1
    npush = 0;
    npop  = 0;
    for (int c = 0; c < 40 && npop < 12; c++) begin
      drive(npush < 12, 2'd1, 8'h10 + 8'(npush), {2'b00, ((c % 2) == 1) || (npush == 12), 1'b0});
      if (out_valid[1] !== (npush > npop)) begin
        chk("wrap_out_valid", {31'd0, out_valid[1]}, {31'd0, (npush > npop)});
      end
      if (read[1] && out_valid[1]) begin
        lane = out_data[15:8];
        chk($sformatf("wrap_pop%0d", npop), {24'd0, lane}, 32'h10 + npop);
        npop++;
      end
      if (in_valid && in_ready) npush++;
      tick();
    end
    chk("wrap_pop_count", npop, 32'd12);
    idle_tick();
    chk("wrap_empty", {31'd0, out_valid[1]}, 32'd0);

    // Simultaneous push and pop on channel 3 at count 4
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd3, 8'h30 + 8'(k), 4'b0000);
      tick();
    end
    drive(1'b1, 2'd3, 8'h34, 4'b1000);
    tick();
    chk("sim3_af", {31'd0, almost_full[3]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'd3, 8'h00, 4'b1000);
      chk($sformatf("sim3_word%0d", k), {24'd0, out_data[31:24]}, 32'h31 + k);
      tick();
    end
    chk("sim3_count4", {31'd0, out_valid[3]}, 32'd0);

    // Push and pop on empty channel 0
    drive(1'b1, 2'd0, 8'h05, 4'b0001);
    tick();
    chk("empty0_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("empty0_data", {24'd0, out_data[7:0]}, 32'h05);
    drive(1'b0, 2'd0, 8'h00, 4'b0001);
    tick();
    chk("empty0_count1", {31'd0, out_valid[0]}, 32'd0);

    // Reset mid-operation with channel 1 at count 5
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'd1, 8'h50 + 8'(k), 4'b0000);
      tick();
    end
    drive(1'b0, 2'd1, 8'h00, 4'b0000);
    chk("pre_rst_valid1", {28'd0, out_valid}, 32'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_almost_full", {28'd0, almost_full}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_release_ready", {31'd0, in_ready}, 32'd1);
    tick();

`ifdef DISP_N_ERR_EN
    chk("err_init", {28'd0, err_underflow}, 32'd0);
    drive(1'b0, 2'd0, 8'h00, 4'b0100);
    tick();
    chk("err_set", {28'd0, err_underflow}, 32'h4);
    drive(1'b1, 2'd2, 8'h77, 4'b0000);
    tick();
    drive(1'b0, 2'd2, 8'h00, 4'b0100);
    tick();
    chk("err_held", {28'd0, err_underflow}, 32'h4);
    chk("err_no_side_effect", {28'd0, out_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("err_reset", {28'd0, err_underflow}, 32'd0);
    reset = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
